chunked_adder: RTL

CHUNKED_ADDER -- requirements
Module: chunked_adder

---
 rtl/chunked_adder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock over WIDTH/CHUNK slices
// and reports x86-style CF/OF/ZF/SF flags with a valid/ready handshake on both sides.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready=1
// RUN   | one slice per edge, running carry held in carry_q
// DONE  | result/flags presented, out_valid=1 until out_ready
module chunked_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
    input  logic [1:0]       mode,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             CF,
    output logic             OF,
    output logic             ZF,
    output logic             SF
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             sub_q;
    logic [KW-1:0]    k_q;
    logic             cf_q, of_q, zf_q, sf_q;

    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK:0]   sum_sl;
    logic             cout;
    logic             cmsb;
    logic             last_sl;

    always_comb begin
        a_sl    = a_q[int'(k_q)*CHUNK +: CHUNK];
        b_sl    = b_q[int'(k_q)*CHUNK +: CHUNK];
        sum_sl  = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
        acc_d   = acc_q;
        acc_d[int'(k_q)*CHUNK +: CHUNK] = sum_sl[CHUNK-1:0];
        cout    = sum_sl[CHUNK];
        // sum bit = a ^ b ^ carry-in, so the carry into the top bit falls out directly
        cmsb    = sum_sl[CHUNK-1] ^ a_sl[CHUNK-1] ^ b_sl[CHUNK-1];
        last_sl = (k_q == KW'(N - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            sub_q    <= 1'b0;
            k_q      <= '0;
            cf_q     <= 1'b0;
            of_q     <= 1'b0;
            zf_q     <= 1'b0;
            sf_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= dataa;
                        b_q     <= mode[0] ? ~datab : datab;
                        carry_q <= mode[1] ? (carry_in ^ mode[0]) : mode[0];
                        sub_q   <= mode[0];
                        acc_q   <= '0;
                        k_q     <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= cout;
                    k_q     <= k_q + KW'(1);
                    if (last_sl) begin
                        result_q <= acc_d;
                        cf_q     <= cout ^ sub_q;
                        of_q     <= cout ^ cmsb;
                        zf_q     <= (acc_d == '0);
                        sf_q     <= acc_d[WIDTH-1];
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign CF        = cf_q;
    assign OF        = of_q;
    assign ZF        = zf_q;
    assign SF        = sf_q;

endmodule
